// File: rtl/main_mem_responder.sv
// Main-memory responder for a data cache: one outstanding line refill or
// writeback at a time, completed LATENCY cycles after acceptance.
module main_mem_responder #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned MEM_ADDR_LEN  = 10,
  parameter int unsigned LATENCY       = 50
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_req,
  input  logic                              wr_req,
  input  logic [31:0]                       addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]  wr_line,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]  rd_line,
  output logic                              gnt,
  output logic                              busy,
  output logic [31:0]                       rd_count,
  output logic [31:0]                       wr_count
);

  localparam int unsigned LINE_W = 32 * (2 ** LINE_ADDR_LEN);
  localparam int unsigned SLOTS  = 2 ** MEM_ADDR_LEN;
  localparam int unsigned IDX_LO = LINE_ADDR_LEN + 2;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [7:0]                r_cnt;
  logic [7:0]                w_cnt_next;
  logic                      w_accept;
  logic                      w_access;
  logic                      r_is_wr;
  logic [MEM_ADDR_LEN-1:0]   r_idx;
  logic [MEM_ADDR_LEN-1:0]   w_req_idx;
  logic [LINE_W-1:0]         r_wline;
  logic [LINE_W-1:0]         r_rd_line;
  logic [31:0]               r_rd_count;
  logic [31:0]               r_wr_count;
  logic [LINE_W-1:0]         r_mem [SLOTS];
  logic [31:0]               w_addr_unused;

  // Tag and byte-offset bits take no part in addressing the array.
  assign w_addr_unused = addr;
  assign w_req_idx     = addr[IDX_LO +: MEM_ADDR_LEN];

  assign gnt      = (r_state == DONE);
  assign busy     = (r_state != IDLE);
  assign rd_line  = r_rd_line;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

  // Next-state, countdown and acceptance/access strobes.
  // The DONE cycle also samples requests so that back-to-back transactions
  // are spaced exactly LATENCY+1 cycles apart; write wins over read.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_access   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rd_req || wr_req) begin
          w_next   = BUSY;
          w_accept = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_access = 1'b1;
          w_next   = DONE;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      DONE: begin
        if (rd_req || wr_req) begin
          w_next   = BUSY;
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_accept) w_cnt_next = LAT_M1;
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the transaction at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_wline <= '0;
    end else if (w_accept) begin
      r_is_wr <= wr_req;
      r_idx   <= w_req_idx;
      r_wline <= wr_line;
    end
  end

  // Line array: not reset; written only at the access edge of a write.
  always_ff @(posedge clk) begin
    if (w_access && r_is_wr) r_mem[r_idx] <= r_wline;
  end

  // Refill data and completion counters, updated at the access edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_line  <= '0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_access) begin
      if (r_is_wr) begin
        r_wr_count <= r_wr_count + 32'd1;
      end else begin
        r_rd_line  <= r_mem[r_idx];
        r_rd_count <= r_rd_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: directed scenarios plus
// randomized requests, checked every cycle against a transaction-level model.
module tb_main_mem_responder;

  localparam int unsigned LAL = 3;
  localparam int unsigned MAL = 10;
  localparam int unsigned LAT = 4;
  localparam int          LW  = 32 * (1 << LAL);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [31:0]   addr = '0;
  logic [LW-1:0] wr_line = '0;
  logic [LW-1:0] rd_line;
  logic          gnt;
  logic          busy;
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;

  always #5 clk = ~clk;

  main_mem_responder #(
    .LINE_ADDR_LEN(LAL),
    .MEM_ADDR_LEN (MAL),
    .LATENCY      (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .addr    (addr),
    .wr_line (wr_line),
    .rd_line (rd_line),
    .gnt     (gnt),
    .busy    (busy),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level model: a pending transaction completes at an absolute
  // cycle number; the array is a plain memory with per-slot "written" flags.
  logic [LW-1:0] m_mem [1 << MAL];
  bit            m_val [1 << MAL];
  bit            m_pend = 1'b0;
  int            m_done = 0;
  bit            m_is_wr = 1'b0;
  int            m_idx = 0;
  logic [LW-1:0] m_wl = '0;
  logic [LW-1:0] m_rd = '0;
  bit            m_rd_known = 1'b1;
  logic [31:0]   m_rc = '0;
  logic [31:0]   m_wc = '0;

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> (LAL + 2)) & ((32'd1 << MAL) - 32'd1));
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_8000) | (($urandom % 8) << 5) | ($urandom % 32);
    return a;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_pend     = 1'b0;
      m_rd       = '0;
      m_rd_known = 1'b1;
      m_rc       = '0;
      m_wc       = '0;
    end else begin
      cyc++;
      if (m_pend && cyc == m_done) begin
        if (m_is_wr) begin
          m_mem[m_idx] = m_wl;
          m_val[m_idx] = 1'b1;
          m_wc++;
        end else begin
          m_rd       = m_mem[m_idx];
          m_rd_known = m_val[m_idx];
          m_rc++;
        end
      end
      if (m_pend && cyc == m_done + 1) m_pend = 1'b0;
      if (!m_pend && (rd_req || wr_req)) begin
        m_pend  = 1'b1;
        m_done  = cyc + int'(LAT);
        m_is_wr = wr_req;
        m_idx   = idx_of(addr);
        m_wl    = wr_line;
      end
    end
  end

  task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    chk("gnt", gnt, m_pend && (cyc == m_done));
    chk("busy", busy, m_pend);
    chk("rd_count", rd_count, m_rc);
    chk("wr_count", wr_count, m_wc);
    if (m_rd_known) chk("rd_line", rd_line, m_rd);
  end

  task automatic set_req(bit r, bit w, logic [31:0] a, logic [LW-1:0] l);
    rd_req  = r;
    wr_req  = w;
    addr    = a;
    wr_line = l;
  endtask

  task automatic wait_gnt(string nm, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < int'(LAT) + 8 && !seen; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no gnt, required gnt within %0d cycles", nm, LAT + 8);
    end
  endtask

  task automatic txn(string nm, bit r, bit w, logic [31:0] a, logic [LW-1:0] l,
                     output int acc, output int gat);
    set_req(r, w, a, l);
    @(negedge clk);
    acc = cyc;
    chk({nm, "_busy"}, busy, 1'b1);
    wait_gnt(nm, gat);
    set_req(1'b0, 1'b0, a, l);
  endtask

  localparam logic [LW-1:0] L1 =
    256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

  initial begin
    int a, g, a2, g2, ng, k;
    int t [3];
    logic [LW-1:0] l2, la, lb, lc, ld, le, lf;

    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_line", rd_line, '0);
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_wr_count", wr_count, 32'd0);
    #2 rst = 1'b1;

    // Write then read one line; latency and counters pinned by literals.
    txn("t33_wr", 1'b0, 1'b1, 32'h0000_1000, L1, a, g);
    chk("t33_wr_lat", 32'(g - a), 32'd4);
    txn("t33_rd", 1'b1, 1'b0, 32'h0000_1000, '0, a, g);
    chk("t33_rd_lat", 32'(g - a), 32'd4);
    chk("t33_rd_line", rd_line, L1);
    chk("t33_rd_count", rd_count, 32'd1);
    chk("t33_wr_count", wr_count, 32'd1);

    // Simultaneous read and write: write first, read taken at acceptance+5.
    l2 = rnd_line();
    set_req(1'b1, 1'b1, 32'h0000_0040, l2);
    @(negedge clk);
    a = cyc;
    wait_gnt("t34_wr", g);
    chk("t34_wr_lat", 32'(g - a), 32'd4);
    chk("t34_wr_count", wr_count, 32'd2);
    chk("t34_rd_line_kept", rd_line, L1);
    rd_req = 1'b1;
    wr_req = 1'b0;
    @(negedge clk);
    a2 = cyc;
    chk("t34_rd_gap", 32'(a2 - a), 32'd5);
    chk("t34_rd_busy", busy, 1'b1);
    chk("t34_rd_nognt", gnt, 1'b0);
    wait_gnt("t34_rd", g2);
    chk("t34_rd_lat", 32'(g2 - a2), 32'd4);
    chk("t34_rd_line", rd_line, l2);
    set_req(1'b0, 1'b0, 32'h0, '0);

    // Aliasing: index is addr[14:5]; 0x8020 aliases 0x20, 0x2020 does not.
    la = rnd_line();
    lb = rnd_line();
    lc = rnd_line();
    txn("t35_wa", 1'b0, 1'b1, 32'h0000_0020, la, a, g);
    txn("t35_wb", 1'b0, 1'b1, 32'h0000_8020, lb, a, g);
    txn("t35_r1", 1'b1, 1'b0, 32'h0000_0020, '0, a, g);
    chk("t35_alias", rd_line, lb);
    txn("t35_wc", 1'b0, 1'b1, 32'h0000_2020, lc, a, g);
    txn("t35_r2", 1'b1, 1'b0, 32'h0000_0020, '0, a, g);
    chk("t35_distinct", rd_line, lb);
    txn("t35_r3", 1'b1, 1'b0, 32'h0000_2020, '0, a, g);
    chk("t35_other", rd_line, lc);

    // Inputs churn during BUSY: the latched transaction is unaffected.
    ld = rnd_line();
    set_req(1'b0, 1'b1, 32'h0000_0060, ld);
    ng = 0;
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) begin
        ng++;
        wr_req = 1'b0;
      end else if (wr_req) begin
        addr    = $urandom;
        wr_line = rnd_line();
      end
    end
    chk("t36_one_gnt", 32'(ng), 32'd1);
    txn("t36_rd", 1'b1, 1'b0, 32'h0000_0060, '0, a, g);
    chk("t36_rd_line", rd_line, ld);

    // Reset during a write abandons it; request at first edge after reset.
    lf = rnd_line();
    le = rnd_line();
    txn("t37_wf", 1'b0, 1'b1, 32'h0000_0080, lf, a, g);
    set_req(1'b0, 1'b1, 32'h0000_0080, le);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, '0);
    ng = 0;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      @(negedge clk);
      if (gnt !== 1'b0) ng++;
    end
    chk("t37_no_gnt", 32'(ng), 32'd0);
    chk("t37_busy", busy, 1'b0);
    chk("t37_wr_count", wr_count, 32'd0);
    set_req(1'b1, 1'b0, 32'h0000_0080, '0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t37_first_edge_acc", busy, 1'b1);
    wait_gnt("t37_rd", g);
    set_req(1'b0, 1'b0, 32'h0, '0);
    chk("t37_rd_count", rd_count, 32'd1);

    // rd_req held continuously for three transactions.
    set_req(1'b1, 1'b0, 32'h0000_1000, '0);
    k = 0;
    for (int i = 0; i < 3 * (int'(LAT) + 1) + 10 && k < 3; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) begin
        t[k] = cyc;
        k++;
        if (k == 3) rd_req = 1'b0;
      end
    end
    chk("t38_gnts", 32'(k), 32'd3);
    chk("t38_space1", 32'(t[1] - t[0]), 32'd5);
    chk("t38_space2", 32'(t[2] - t[1]), 32'd5);
    @(negedge clk);
    chk("t38_rd_count", rd_count, 32'd4);
    chk("t38_rd_line", rd_line, L1);

    // Randomized traffic over 8 indices with random tag bits.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rd_req  = ($urandom % 4) == 0;
      wr_req  = ($urandom % 4) == 0;
      addr    = rnd_addr();
      wr_line = rnd_line();
    end
    set_req(1'b0, 1'b0, 32'h0, '0);
    repeat (LAT + 4) @(negedge clk);
    chk("end_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
